fd_result_buffer: RTL and testbench

FD_RESULT_BUFFER -- requirements
Module: fd_result_buffer

---
 rtl/fd_result_buffer.sv | 109 ++++++++++
 tb/tb_fd_result_buffer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fd_result_buffer.sv
// Result FIFO between the fast divider and its consumer; first-word fall-through.
// Optional divide-by-zero event counter enabled by defining FD_DBZ_COUNT_EN.
module fd_result_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           quotient_in,
  input  logic [WIDTH-1:0]           remainder_in,
  input  logic                       dbz_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           quotient_out,
  output logic [WIDTH-1:0]           remainder_out,
  output logic                       dbz_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       full_out,
  output logic                       empty_out
`ifdef FD_DBZ_COUNT_EN
  ,
  input  logic                       dbz_clear_in,
  output logic [7:0]                 dbz_count_out
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = 2*WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          run_q;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  assign full_out  = (count == DEPTH_C);
  assign empty_out = (count == '0);
  assign in_ready  = !full_out;
  assign out_valid = !empty_out;
  assign count_out = count;

  // run_q holds pushes off until one full edge after reset release.
  assign push = in_valid && in_ready && run_q;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {quotient_in, remainder_in, dbz_in};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    head = '0;
    if (!empty_out) head = mem[rd_ptr];
  end

  assign quotient_out  = head[EW-1 -: WIDTH];
  assign remainder_out = head[WIDTH:1];
  assign dbz_out       = head[0];

`ifdef FD_DBZ_COUNT_EN
  logic [7:0] dbz_count;

  // Clear takes priority over a same-edge increment; count saturates at 255.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dbz_count <= '0;
    end else if (dbz_clear_in) begin
      dbz_count <= '0;
    end else if (push && dbz_in && dbz_count != 8'hFF) begin
      dbz_count <= dbz_count + 8'd1;
    end
  end

  assign dbz_count_out = dbz_count;
`endif

endmodule

// File: tb/tb_fd_result_buffer.sv
// Directed, table-driven bench for fd_result_buffer (WIDTH=8, DEPTH=4).
// Also exercises the divide-by-zero counter when FD_DBZ_COUNT_EN is defined.
module tb_fd_result_buffer;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] quotient_in;
  logic [7:0] remainder_in;
  logic       dbz_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient_out;
  logic [7:0] remainder_out;
  logic       dbz_out;
  logic [2:0] count_out;
  logic       full_out;
  logic       empty_out;
`ifdef FD_DBZ_COUNT_EN
  logic       dbz_clear_in;
  logic [7:0] dbz_count_out;
`endif

  int checks = 0;
  int errors = 0;

  fd_result_buffer #(.WIDTH(8), .DEPTH(4)) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .quotient_in(quotient_in),
    .remainder_in(remainder_in),
    .dbz_in(dbz_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient_out(quotient_out),
    .remainder_out(remainder_out),
    .dbz_out(dbz_out),
    .count_out(count_out),
    .full_out(full_out),
    .empty_out(empty_out)
`ifdef FD_DBZ_COUNT_EN
    ,
    .dbz_clear_in(dbz_clear_in),
    .dbz_count_out(dbz_count_out)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       iv;
    logic [7:0] q;
    logic [7:0] r;
    logic       d;
    logic       ordy;
    logic       ev;
    logic [7:0] eq;
    logic [7:0] er;
    logic       ed;
    logic [2:0] ec;
    logic       efull;
    logic       eempty;
    logic       erdy;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(logic iv, logic [7:0] q, logic [7:0] r, logic d, logic ordy,
                                 logic ev, logic [7:0] eq, logic [7:0] er, logic ed,
                                 logic [2:0] ec, logic efull, logic eempty, logic erdy);
    vec_t v;
    v.iv = iv; v.q = q; v.r = r; v.d = d; v.ordy = ordy;
    v.ev = ev; v.eq = eq; v.er = er; v.ed = ed;
    v.ec = ec; v.efull = efull; v.eempty = eempty; v.erdy = erdy;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Check every visible status/data output against one expected set.
  task automatic checkAll(input string tag, input logic ev, input logic [7:0] eq,
                          input logic [7:0] er, input logic ed, input logic [2:0] ec,
                          input logic efull, input logic eempty, input logic erdy);
    checkOutput({tag, ".out_valid"}, int'(out_valid), int'(ev));
    checkOutput({tag, ".quotient"}, int'(quotient_out), int'(eq));
    checkOutput({tag, ".remainder"}, int'(remainder_out), int'(er));
    checkOutput({tag, ".dbz"}, int'(dbz_out), int'(ed));
    checkOutput({tag, ".count"}, int'(count_out), int'(ec));
    checkOutput({tag, ".full"}, int'(full_out), int'(efull));
    checkOutput({tag, ".empty"}, int'(empty_out), int'(eempty));
    checkOutput({tag, ".in_ready"}, int'(in_ready), int'(erdy));
  endtask

  task automatic applyStimulus(input logic iv, input logic [7:0] q, input logic [7:0] r,
                               input logic d, input logic ordy);
    in_valid     = iv;
    quotient_in  = q;
    remainder_in = r;
    dbz_in       = d;
    out_ready    = ordy;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    in_valid     = 1'b0;
    quotient_in  = '0;
    remainder_in = '0;
    dbz_in       = 1'b0;
    out_ready    = 1'b0;
`ifdef FD_DBZ_COUNT_EN
    dbz_clear_in = 1'b0;
`endif

    // Single push then pop.
    addVec(1, 8'h07, 8'h02, 0, 0,  1, 8'h07, 8'h02, 0, 3'd1, 0, 0, 1);
    addVec(0, 8'h00, 8'h00, 0, 1,  0, 8'h00, 8'h00, 0, 3'd0, 0, 1, 1);
    // Fill with q=1..5, consumer stalled; fifth is dropped.
    for (int q = 1; q <= 5; q++) begin
      addVec(1, 8'(q), 8'(8'h10 + q), (q == 3), 0,
             1, 8'h01, 8'h11, 0, 3'((q > 4) ? 4 : q), (q >= 4), 0, (q < 4));
    end
    addVec(0, 8'h00, 8'h00, 0, 0,  1, 8'h01, 8'h11, 0, 3'd4, 1, 0, 0);
    // Full with push and pop offered: only the pop happens.
    addVec(1, 8'h66, 8'h77, 1, 1,  1, 8'h02, 8'h12, 0, 3'd3, 0, 0, 1);
    addVec(0, 8'h00, 8'h00, 0, 1,  1, 8'h03, 8'h13, 1, 3'd2, 0, 0, 1);
    // Ten simultaneous push/pop at count 2; pointers wrap several times.
    for (int k = 0; k < 10; k++) begin
      if (k == 0)
        addVec(1, 8'h20, 8'h30, 0, 1,  1, 8'h04, 8'h14, 0, 3'd2, 0, 0, 1);
      else
        addVec(1, 8'(8'h20 + k), 8'(8'h30 + k), 1'(k % 2), 1,
               1, 8'(8'h20 + k - 1), 8'(8'h30 + k - 1), 1'((k - 1) % 2), 3'd2, 0, 0, 1);
    end
    addVec(0, 8'h00, 8'h00, 0, 1,  1, 8'h29, 8'h39, 1, 3'd1, 0, 0, 1);
    addVec(0, 8'h00, 8'h00, 0, 1,  0, 8'h00, 8'h00, 0, 3'd0, 0, 1, 1);

    #1;
    checkAll("reset", 0, 8'h00, 8'h00, 0, 3'd0, 0, 1, 1);
    #12 reset = 1'b1;
    @(posedge clock);
    #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].iv, vecs[i].q, vecs[i].r, vecs[i].d, vecs[i].ordy);
      checkAll($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eq, vecs[i].er, vecs[i].ed,
               vecs[i].ec, vecs[i].efull, vecs[i].eempty, vecs[i].erdy);
    end

    // Asynchronous reset between edges at count 3, then release synchronisation.
    for (int q = 1; q <= 3; q++) applyStimulus(1, 8'(8'h40 + q), 8'h50, 0, 0);
    checkOutput("pre_reset.count", int'(count_out), 3);
    applyStimulus(0, 8'h00, 8'h00, 0, 0);
    #2 reset = 1'b0;
    #1;
    checkAll("async_reset", 0, 8'h00, 8'h00, 0, 3'd0, 0, 1, 1);
    reset = 1'b1;
    applyStimulus(1, 8'hAA, 8'hBB, 1, 0);
    checkAll("release_edge1", 0, 8'h00, 8'h00, 0, 3'd0, 0, 1, 1);
    applyStimulus(1, 8'hAA, 8'hBB, 1, 0);
    checkAll("release_edge2", 1, 8'hAA, 8'hBB, 1, 3'd1, 0, 0, 1);

`ifdef FD_DBZ_COUNT_EN
    applyStimulus(0, 8'h00, 8'h00, 0, 1);
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    applyStimulus(0, 8'h00, 8'h00, 0, 1);
    checkOutput("dbz_count.reset", int'(dbz_count_out), 0);
    for (int n = 0; n < 300; n++) applyStimulus(1, 8'(n), 8'h00, 1, 1);
    checkOutput("dbz_count.saturate", int'(dbz_count_out), 255);
    dbz_clear_in = 1'b1;
    applyStimulus(1, 8'h01, 8'h00, 1, 1);
    dbz_clear_in = 1'b0;
    checkOutput("dbz_count.clear", int'(dbz_count_out), 0);
    applyStimulus(1, 8'h02, 8'h00, 1, 1);
    checkOutput("dbz_count.after_clear", int'(dbz_count_out), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
